// File: rtl/wb_pkg.sv
// Shared types and defaults for the integer register file write-back path.
package wb_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_AW    = 5;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_AW-1:0]   rd;
        logic [DEF_XLEN-1:0] data;
    } wb_req_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/wb_req_fifo.sv
// In-order request FIFO for LSU/multi-cycle results; exposes its storage so the
// write-back stage can search pending values for decode bypass.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter type entry_t = wb_req_t,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head_data,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty,
    output entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [PW-1:0]            tail_ptr
);

    entry_t [DEPTH-1:0] mem;
    logic   [PW-1:0]    head_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem[head_ptr];
    assign entries   = mem;

    // Pointers wrap naturally because DEPTH is a power of two; the extra count
    // bit is what separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= tail_ptr + PW'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PW-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PW'(i) - head_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/regfile_wb_writer.sv
// Write-back producer: arbitrates EX and buffered LSU results onto the single
// register file write port and answers decode bypass queries.
module regfile_wb_writer
    import wb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   byp_addr,
    output logic            byp_hit,
    output logic [XLEN-1:0] byp_data,
    output logic [CW-1:0]   fifo_count,
    output logic            idle
);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } req_t;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic               running;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    req_t               fifo_head;
    req_t               push_req;
    req_t [DEPTH-1:0]   fifo_entries;
    logic [DEPTH-1:0]   fifo_entry_valid;
    logic [PW-1:0]      fifo_tail;
    logic               sel_valid;
    req_t               sel_req;

    wb_req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .push_data   (push_req),
        .pop         (fifo_pop),
        .head_data   (fifo_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entries     (fifo_entries),
        .entry_valid (fifo_entry_valid),
        .tail_ptr    (fifo_tail)
    );

    // Held low through reset so neither producer hands off while state is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    assign ex_ready  = running & ~fifo_full;
    assign lsu_ready = running & (fifo_count < CW'(DEPTH));
    assign fifo_push = lsu_valid & lsu_ready;
    assign push_req  = '{rd: lsu_rd, data: lsu_data};
    assign idle      = (fifo_count == '0) & ~rf_wen;

    // A full FIFO wins over EX so a steady EX stream cannot starve the LSU.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        fifo_pop  = 1'b0;
        if (fifo_full) begin
            sel_valid = 1'b1;
            sel_req   = fifo_head;
            fifo_pop  = 1'b1;
        end else if (ex_valid && running) begin
            sel_valid = 1'b1;
            sel_req   = '{rd: ex_rd, data: ex_data};
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_req   = fifo_head;
            fifo_pop  = 1'b1;
        end
    end

    // x0 results are consumed but never written; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= sel_valid && (sel_req.rd != ZERO_ADDR);
            if (sel_valid && (sel_req.rd != ZERO_ADDR)) begin
                rf_waddr <= sel_req.rd;
                rf_wdata <= sel_req.data;
            end
        end
    end

    // Oldest candidate first so younger matches overwrite; the FIFO scan runs
    // from the head side toward the tail, ending on the youngest entry.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_addr != ZERO_ADDR) begin
            if (rf_wen && (rf_waddr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = rf_wdata;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                idx = fifo_tail - PW'(k) - PW'(1);
                if (fifo_entry_valid[idx] && (fifo_entries[idx].rd == byp_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = fifo_entries[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed table-driven bench for regfile_wb_writer with hand-written
// sequences for FIFO starvation, bypass priority and mid-drain reset.
module tb_regfile_wb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [63:0] ex_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [63:0] byp_data;
    logic [2:0]  fifo_count;
    logic        idle;

    int errors = 0;
    int checks = 0;
    int write_count = 0;
    logic [63:0] last_rd3 = '0;

    regfile_wb_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .byp_addr   (byp_addr),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Register file writes are one-cycle pulses; negedge sees each exactly once.
    always @(negedge clk) begin
        if (rf_wen) begin
            write_count++;
            if (rf_waddr == 5'd3) last_rd3 = rf_wdata;
        end
    end

    typedef struct {
        logic        ex_v;
        logic [4:0]  ex_r;
        logic [63:0] ex_d;
        logic        ls_v;
        logic [4:0]  ls_r;
        logic [63:0] ls_d;
        logic [4:0]  byp;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic        e_exr;
        logic        e_lsr;
        logic [2:0]  e_cnt;
        logic        e_hit;
        logic [63:0] e_byp;
    } vec_t;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [4:0] er, input logic [63:0] ed,
                                 input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                                 input logic [4:0] ba);
        ex_valid  = ev;
        ex_rd     = er;
        ex_data   = ed;
        lsu_valid = lv;
        lsu_rd    = lr;
        lsu_data  = ld;
        byp_addr  = ba;
    endtask

    task automatic checkOutput(input vec_t v, input int n);
        checkVal($sformatf("v%0d rf_wen", n), 64'(rf_wen), 64'(v.e_wen));
        checkVal($sformatf("v%0d rf_waddr", n), 64'(rf_waddr), 64'(v.e_addr));
        checkVal($sformatf("v%0d rf_wdata", n), rf_wdata, v.e_data);
        checkVal($sformatf("v%0d ex_ready", n), 64'(ex_ready), 64'(v.e_exr));
        checkVal($sformatf("v%0d lsu_ready", n), 64'(lsu_ready), 64'(v.e_lsr));
        checkVal($sformatf("v%0d fifo_count", n), 64'(fifo_count), 64'(v.e_cnt));
        checkVal($sformatf("v%0d byp_hit", n), 64'(byp_hit), 64'(v.e_hit));
        checkVal($sformatf("v%0d byp_data", n), byp_data, v.e_byp);
    endtask

    task automatic idleInputs(input logic [4:0] ba);
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ba);
    endtask

    task automatic waitIdle(input string name);
        bit done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            #1;
            if (idle) done = 1;
        end
        checkVal({name, " drain to idle"}, 64'(done), 64'd1);
    endtask

    vec_t vecs[12];

    initial begin
        //                ex_v ex_r   ex_d      ls_v ls_r   ls_d    byp   wen addr   data       exr lsr cnt hit byp
        vecs[0]  = '{1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  64'h0,  5'd5,  1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd5,  1'b1, 5'd5,  64'h1234, 1'b1, 1'b1, 3'd0, 1'b1, 64'h1234};
        vecs[2]  = '{1'b1, 5'd0,  64'hDEAD, 1'b0, 5'd0,  64'h0,  5'd0,  1'b0, 5'd5,  64'h1234, 1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd5,  1'b0, 5'd5,  64'h1234, 1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[4]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd12, 64'h55, 5'd12, 1'b0, 5'd5,  64'h1234, 1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd12, 1'b0, 5'd5,  64'h1234, 1'b1, 1'b1, 3'd1, 1'b1, 64'h55};
        vecs[6]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd12, 1'b1, 5'd12, 64'h55,   1'b1, 1'b1, 3'd0, 1'b1, 64'h55};
        vecs[7]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd12, 1'b0, 5'd12, 64'h55,   1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, 5'd6,  64'h66,   1'b1, 5'd13, 64'h77, 5'd13, 1'b0, 5'd12, 64'h55,   1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd13, 1'b1, 5'd6,  64'h66,   1'b1, 1'b1, 3'd1, 1'b1, 64'h77};
        vecs[10] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd6,  1'b1, 5'd13, 64'h77,   1'b1, 1'b1, 3'd0, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd13, 1'b0, 5'd13, 64'h77,   1'b1, 1'b1, 3'd0, 1'b0, 64'h0};

        // Reset held with both producers requesting.
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 5'd0);
        repeat (3) @(negedge clk);
        #1;
        checkVal("reset rf_wen", 64'(rf_wen), 64'd0);
        checkVal("reset rf_waddr", 64'(rf_waddr), 64'd0);
        checkVal("reset rf_wdata", rf_wdata, 64'd0);
        checkVal("reset ex_ready", 64'(ex_ready), 64'd0);
        checkVal("reset lsu_ready", 64'(lsu_ready), 64'd0);
        checkVal("reset fifo_count", 64'(fifo_count), 64'd0);
        idleInputs(5'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkVal("release ex_ready", 64'(ex_ready), 64'd1);
        checkVal("release lsu_ready", 64'(lsu_ready), 64'd1);
        checkVal("release idle", 64'(idle), 64'd1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].ex_v, vecs[i].ex_r, vecs[i].ex_d,
                          vecs[i].ls_v, vecs[i].ls_r, vecs[i].ls_d, vecs[i].byp);
            #1;
            checkOutput(vecs[i], i);
        end

        // Starvation guard: EX streams while the LSU fills the FIFO.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 5'(20 + i), 64'h2000 + 64'(i), 1'b1, 5'(7 + i), 64'h100 + 64'(7 + i), 5'd0);
        end
        @(negedge clk);
        applyStimulus(1'b1, 5'd25, 64'h2005, 1'b0, 5'd0, 64'h0, 5'd0);
        #1;
        checkVal("full fifo_count", 64'(fifo_count), 64'd4);
        checkVal("full lsu_ready", 64'(lsu_ready), 64'd0);
        checkVal("full ex_ready", 64'(ex_ready), 64'd0);
        @(negedge clk);
        idleInputs(5'd0);
        #1;
        checkVal("starve rf_wen", 64'(rf_wen), 64'd1);
        checkVal("starve rf_waddr", 64'(rf_waddr), 64'd7);
        checkVal("starve rf_wdata", rf_wdata, 64'h107);
        checkVal("starve fifo_count", 64'(fifo_count), 64'd3);
        checkVal("starve lsu_ready", 64'(lsu_ready), 64'd1);
        @(negedge clk);
        #1;
        checkVal("order rf_waddr", 64'(rf_waddr), 64'd8);
        checkVal("order rf_wdata", rf_wdata, 64'h108);
        waitIdle("starve");

        // Bypass priority: two queued rd=3 values younger than the rd=3 in the output stage.
        @(negedge clk);
        applyStimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd3, 64'hA, 5'd0);
        @(negedge clk);
        applyStimulus(1'b1, 5'd2, 64'h2, 1'b1, 5'd3, 64'hB, 5'd0);
        @(negedge clk);
        applyStimulus(1'b1, 5'd3, 64'h9, 1'b0, 5'd0, 64'h0, 5'd0);
        @(negedge clk);
        idleInputs(5'd3);
        #1;
        checkVal("byp stage rf_wdata", rf_wdata, 64'h9);
        checkVal("byp stage fifo_count", 64'(fifo_count), 64'd2);
        checkVal("byp youngest hit", 64'(byp_hit), 64'd1);
        checkVal("byp youngest data", byp_data, 64'hB);
        @(negedge clk);
        #1;
        checkVal("byp after pop data", byp_data, 64'hB);
        waitIdle("bypass");
        checkVal("last rd3 write", last_rd3, 64'hB);

        // Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 5'(21 + i), 64'h3000 + 64'(i), 1'b1, 5'(14 + i), 64'h400 + 64'(i), 5'd0);
        end
        @(negedge clk);
        idleInputs(5'd0);
        @(negedge clk);
        #1;
        checkVal("predrain fifo_count", 64'(fifo_count), 64'd3);
        checkVal("predrain rf_wen", 64'(rf_wen), 64'd1);
        checkVal("predrain rf_waddr", 64'(rf_waddr), 64'd14);
        #1;
        rst_n = 1'b0;
        #1;
        checkVal("midreset rf_wen", 64'(rf_wen), 64'd0);
        checkVal("midreset fifo_count", 64'(fifo_count), 64'd0);
        checkVal("midreset ex_ready", 64'(ex_ready), 64'd0);
        begin
            int snap;
            snap = write_count;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
            #1;
            checkVal("post reset writes", 64'(write_count - snap), 64'd0);
            checkVal("post reset idle", 64'(idle), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
